// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART transmit arbiter.
//   arb_state_e  - arbiter FSM states (IDLE, WRITE)
//   *_DEF        - default NUM_REQ / DATA_W / ADDR_W and grant-index width
//   idx_width()  - width of an index into n requesters (minimum 1)
package uart_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } arb_state_e;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned ADDR_W_DEF  = 3;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned GRANT_W_DEF = idx_width(NUM_REQ_DEF);

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus UART write port.
//   req_valid/req_data/req_last -> arbiter  (producer offers)
//   req_ready                   <- arbiter  (one-hot acceptance)
//   uart_address/uart_w_data/uart_we <- arbiter, uart_full -> arbiter
//   grant_id, busy              <- arbiter  (status)
// Modports: master = producers/UART side, slave = arbiter.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
);
    localparam int unsigned GRANT_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         uart_address;
    logic [DATA_W-1:0]         uart_w_data;
    logic                      uart_we;
    logic                      uart_full;
    logic [GRANT_W-1:0]        grant_id;
    logic                      busy;

    modport master (
        output req_valid, req_data, req_last, uart_full,
        input  req_ready, uart_address, uart_w_data, uart_we, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_full,
        output req_ready, uart_address, uart_w_data, uart_we, grant_id, busy
    );

endinterface

// File: rtl/uart_tx_arbiter_pick.sv
// rr_priority_pick: combinational round-robin picker.
//   eligible_i - requesters allowed to win this cycle
//   ptr_i      - last winner; search starts at ptr_i+1 and wraps
//   winner_o   - first eligible index found
//   any_o      - at least one requester eligible
// N must be a power of two so the index wraps by plain truncation.
module rr_priority_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] eligible_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] winner_o,
    output logic         any_o
);
    logic [W-1:0] idx;

    // Scan from farthest offset (N, i.e. ptr itself) down to 1 so the
    // closest eligible index after ptr is written last and wins.
    always_comb begin
        winner_o = '0;
        idx      = '0;
        any_o    = |eligible_i;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr_i + W'(N - k);
            if (eligible_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the UART TX write port.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - uart_tx_arbiter_if.slave (requesters + UART write port)
// IDLE picks a winner (if UART not full), captures its byte and moves to
// WRITE; WRITE pulses uart_we once the UART is not full, then returns.
// Optional: define UART_ARB_LOCK_EN to keep the grant on one requester
// until it hands over a byte flagged req_last.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned GW = idx_width(NUM_REQ);

    arb_state_e          state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       gid_q, gid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_REQ-1:0]  ready;
    logic                we;
    logic [NUM_REQ-1:0]  eligible;
    logic [GW-1:0]       winner;
    logic                any;

`ifdef UART_ARB_LOCK_EN
    logic                lock_q, lock_d;
    logic [GW-1:0]       lock_id_q, lock_id_d;
    logic [NUM_REQ-1:0]  lock_mask;

    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_id_q] = 1'b1;
        eligible             = lock_q ? (bus.req_valid & lock_mask) : bus.req_valid;
    end
`else
    logic unused_last;

    assign unused_last = ^bus.req_last;
    assign eligible    = bus.req_valid;
`endif

    rr_priority_pick #(
        .N (NUM_REQ),
        .W (GW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (winner),
        .any_o      (any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        addr_d  = addr_q;
        ready   = '0;
        we      = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.uart_full && any) begin
                    ready[winner] = 1'b1;
                    data_d        = bus.req_data[winner*DATA_W +: DATA_W];
                    addr_d        = ADDR_W'(winner);
                    gid_d         = winner;
                    ptr_d         = winner;
                    state_d       = WRITE;
`ifdef UART_ARB_LOCK_EN
                    lock_d    = !bus.req_last[winner];
                    lock_id_d = winner;
`endif
                end
            end
            WRITE: begin
                we = !bus.uart_full;
                if (!bus.uart_full) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= GW'(NUM_REQ - 1);
            gid_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q    <= 1'b0;
            lock_id_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
`ifdef UART_ARB_LOCK_EN
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`endif
        end
    end

    // ready is combinational from inputs; mask it so nothing is offered
    // while reset is held.
    assign bus.req_ready    = ready & {NUM_REQ{rst_n}};
    assign bus.uart_we      = we;
    assign bus.uart_address = addr_q;
    assign bus.uart_w_data  = data_q;
    assign bus.grant_id     = gid_q;
    assign bus.busy         = (state_q == WRITE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(3)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: one pending byte slot, last winner, optional lock.
    bit m_pend = 0;
    int m_last = N - 1;
    int m_addr = 0, m_data = 0, m_gid = 0;
    bit m_lock = 0;
    int m_lock_id = 0;
    int cyc = 0;
    int log_addr[$], log_data[$], log_cyc[$];
    int w;
    logic [3:0] exp_ready;

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (bus.req_valid[i] && (!m_lock || i == m_lock_id)) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_pend = 0; m_last = N - 1; m_addr = 0; m_data = 0; m_gid = 0; m_lock = 0;
        end
        w = pick();
        exp_ready = '0;
        if (rst_n && !m_pend && !bus.uart_full && w >= 0) exp_ready[w] = 1'b1;
        check("ready", 32'(bus.req_ready), 32'(exp_ready));
        check("we", 32'(bus.uart_we), 32'(m_pend && !bus.uart_full));
        check("busy", 32'(bus.busy), 32'(m_pend));
        check("addr", 32'(bus.uart_address), m_addr);
        check("data", 32'(bus.uart_w_data), m_data);
        check("gid", 32'(bus.grant_id), m_gid);
        if (bus.uart_we) begin
            log_addr.push_back(int'(bus.uart_address));
            log_data.push_back(int'(bus.uart_w_data));
            log_cyc.push_back(cyc);
        end
        if (rst_n) begin
            if (m_pend) begin
                if (!bus.uart_full) m_pend = 0;
            end else if (!bus.uart_full && w >= 0) begin
                m_pend = 1;
                m_addr = w;
                m_data = int'(bus.req_data[w*8 +: 8]);
                m_gid  = w;
                m_last = w;
`ifdef UART_ARB_LOCK_EN
                m_lock    = !bus.req_last[w];
                m_lock_id = w;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.uart_full = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] seq_data [4] = '{8'h01, 8'h09, 8'h00, 8'h08};
    logic [7:0] msg [3] = '{8'hB1, 8'hB2, 8'hB3};
    int n0, k, j;
    logic hs;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.uart_full = 1'b0;
        step();
        #1;
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_we", 32'(bus.uart_we), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_data", 32'(bus.uart_w_data), 0);

        // single requester
        do_reset();
        bus.req_data[2*8 +: 8] = 8'h38;
        bus.req_valid = 4'b0100;
        #1 check("t1_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        #1;
        check("t1_we", 32'(bus.uart_we), 1);
        check("t1_addr", 32'(bus.uart_address), 2);
        check("t1_data", 32'(bus.uart_w_data), 32'h38);
        check("t1_busy", 32'(bus.busy), 1);
        step();
        check("t1_we_off", 32'(bus.uart_we), 0);

        // all four valid: order 0,1,2,3, one write per 2 cycles
        do_reset();
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = seq_data[i];
        bus.req_valid = 4'b1111;
        repeat (16) step();
        bus.req_valid = '0;
        step();
        check("t2_count", 32'(log_addr.size() >= 8), 1);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check("t2_addr", log_addr[i], i % 4);
            check("t2_data", log_data[i], int'(seq_data[i % 4]));
            if (i > 0) check("t2_gap", log_cyc[i] - log_cyc[i-1], 2);
        end

        // full while in WRITE
        do_reset();
        bus.req_data[1*8 +: 8] = 8'h55;
        bus.req_valid = 4'b0010;
        step();
        bus.uart_full = 1'b1;
        bus.req_valid = '0;
        n0 = log_addr.size();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_we_held", 32'(bus.uart_we), 0);
            check("t3_data_held", 32'(bus.uart_w_data), 32'h55);
            check("t3_addr_held", 32'(bus.uart_address), 1);
            step();
        end
        bus.uart_full = 1'b0;
        #1 check("t3_we", 32'(bus.uart_we), 1);
        step();
        check("t3_we_once", 32'(bus.uart_we), 0);
        step();
        check("t3_writes", log_addr.size() - n0, 1);

        // full while idle
        do_reset();
        bus.req_data[0 +: 8] = 8'hC4;
        bus.uart_full = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1 check("t4_ready_full", 32'(bus.req_ready), 0);
            step();
        end
        bus.uart_full = 1'b0;
        #1 check("t4_ready", 32'(bus.req_ready), 1);

        // reset during WRITE
        step();
        #1 check("t5_busy", 32'(bus.busy), 1);
        check("t5_data", 32'(bus.uart_w_data), 32'hC4);
        #1 rst_n = 1'b0;
        #1;
        check("t5_r_busy", 32'(bus.busy), 0);
        check("t5_r_we", 32'(bus.uart_we), 0);
        check("t5_r_data", 32'(bus.uart_w_data), 0);
        check("t5_r_addr", 32'(bus.uart_address), 0);
        check("t5_r_gid", 32'(bus.grant_id), 0);
        check("t5_r_ready", 32'(bus.req_ready), 0);
        step();
        rst_n = 1'b1;
        #1 check("t5_first", 32'(bus.req_ready), 1);
        step();
        bus.req_valid = '0;
        step();
        step();

        // multi-byte message from requester 1 while requester 0 is valid
        do_reset();
        n0 = log_addr.size();
        bus.req_last = 4'b0001;
        bus.req_data[0 +: 8] = 8'hA0;
        bus.req_valid = 4'b0001;
        k = 0;
        for (int c = 0; c < 60 && k < 3; c++) begin
            bus.req_valid[1] = 1'b1;
            bus.req_data[1*8 +: 8] = msg[k];
            bus.req_last[1] = (k == 2);
            #3;
            hs = bus.req_ready[1];
            step();
            if (hs) k++;
        end
        check("t6_sent", k, 3);
        bus.req_valid[1] = 1'b0;
        bus.req_last[1] = 1'b0;
        repeat (6) step();
        bus.req_valid = '0;
        step();
        step();
        check("t6_count", 32'(log_addr.size() - n0 >= 5), 1);
        if (log_addr.size() - n0 >= 5) begin
`ifdef UART_ARB_LOCK_EN
            check("t6_a0", log_addr[n0], 0);
            check("t6_a1", log_addr[n0+1], 1);
            check("t6_a2", log_addr[n0+2], 1);
            check("t6_a3", log_addr[n0+3], 1);
            check("t6_a4", log_addr[n0+4], 0);
`else
            check("t6_a0", log_addr[n0], 0);
            check("t6_a1", log_addr[n0+1], 1);
            check("t6_a2", log_addr[n0+2], 0);
            check("t6_a3", log_addr[n0+3], 1);
            check("t6_a4", log_addr[n0+4], 0);
`endif
        end
        j = 0;
        for (int i = n0; i < log_addr.size(); i++) begin
            if (log_addr[i] == 1 && j < 3) begin
                check("t6_msg", log_data[i], int'(msg[j]));
                j++;
            end
        end
        check("t6_msg_cnt", j, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
